// File: rtl/bus_fabric_pkg.sv
// bus_fabric_pkg: shared encodings for the single-master data-bus fabric.
package bus_fabric_pkg;

  // Access size as carried on m_size_i / s_size_o.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Read data returned on any error completion.
  localparam logic [31:0] ERR_RDATA = 32'hBADB_05E5;

  // Transfer state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/bus_fabric_timeout.sv
// bus_fabric_timeout: wait-cycle counter. Load sets it to 1, inc adds one,
// clr zeroes it; term_o flags that the count has reached TIMEOUT.
module bus_fabric_timeout #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic term_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (load_i) cnt_d = CW'(1);
    else if (inc_i)  cnt_d = cnt_q + CW'(1);
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: single master, NUM_SLAVES slave data-bus interconnect with
// ready/wait handshake, unmapped-address errors and error capture.
// Optional wait-timeout errors are built when BUS_FABRIC_TIMEOUT_EN is defined.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int NUM_SLAVES   = 4,
  parameter int SEL_LSB      = 28,
  parameter int SEL_W        = 4,
  parameter int SLAVE_ADDR_W = 16,
  parameter int TIMEOUT      = 64
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [31:0]                      m_addr_i,
  input  logic [31:0]                      m_wdata_i,
  output logic [31:0]                      m_rdata_o,
  input  logic [1:0]                       m_size_i,
  input  logic                             m_rd_i,
  input  logic                             m_wr_i,
  output logic                             m_ready_o,
  output logic                             m_err_o,
  output logic [NUM_SLAVES*SLAVE_ADDR_W-1:0] s_addr_o,
  output logic [NUM_SLAVES*32-1:0]         s_wdata_o,
  input  logic [NUM_SLAVES*32-1:0]         s_rdata_i,
  output logic [NUM_SLAVES*2-1:0]          s_size_o,
  output logic [NUM_SLAVES-1:0]            s_rd_o,
  output logic [NUM_SLAVES-1:0]            s_wr_o,
  input  logic [NUM_SLAVES-1:0]            s_ready_i,
  output logic [31:0]                      err_addr_o,
  output logic [7:0]                       err_count_o
);

  state_e      state_q, state_d;
  logic [SEL_W-1:0] idx;
  logic        req, mapped, sel_ready, strobe_en, tmo;
  logic        cnt_load, cnt_inc, cnt_clr;
  logic [31:0] sel_rdata;
  logic [31:0] err_addr_q;
  logic [7:0]  err_count_q;

  assign req    = m_rd_i | m_wr_i;
  assign idx    = m_addr_i[SEL_LSB +: SEL_W];
  assign mapped = (32'(idx) < 32'(NUM_SLAVES));

  // Pick the addressed slave's ready and read data; zero when unmapped.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx == SEL_W'(k)) begin
        sel_ready = s_ready_i[k];
        sel_rdata = s_rdata_i[k*32 +: 32];
      end
    end
  end

  // Broadcast request fields; strobe only the decoded slave.
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_slv
    assign s_addr_o[k*SLAVE_ADDR_W +: SLAVE_ADDR_W] = m_addr_i[SLAVE_ADDR_W-1:0];
    assign s_wdata_o[k*32 +: 32] = m_wdata_i;
    assign s_size_o[k*2 +: 2]    = m_size_i;
    assign s_rd_o[k] = strobe_en & m_rd_i & (idx == SEL_W'(k));
    assign s_wr_o[k] = strobe_en & m_wr_i & (idx == SEL_W'(k));
  end

`ifdef BUS_FABRIC_TIMEOUT_EN
  bus_fabric_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (cnt_load),
    .inc_i   (cnt_inc),
    .clr_i   (cnt_clr),
    .term_o  (tmo)
  );
`else
  // No timeout hardware: WAIT lasts until the slave answers.
  localparam int unused_timeout = TIMEOUT;
  logic unused_ctl;
  assign unused_ctl = ^{cnt_load, cnt_inc, cnt_clr};
  assign tmo = 1'b0;
`endif

  // Next state and completion; slave ready wins over a coincident timeout.
  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    strobe_en = 1'b0;
    m_ready_o = 1'b0;
    m_err_o   = 1'b0;
    m_rdata_o = sel_rdata;
    if (!reset_i) begin
      if (req) begin
        if (!mapped) begin
          m_ready_o = 1'b1;
          m_err_o   = 1'b1;
          m_rdata_o = ERR_RDATA;
          state_d   = ST_IDLE;
          cnt_clr   = 1'b1;
        end else if (sel_ready) begin
          strobe_en = 1'b1;
          m_ready_o = 1'b1;
          state_d   = ST_IDLE;
          cnt_clr   = 1'b1;
        end else if (state_q == ST_WAIT && tmo) begin
          m_ready_o = 1'b1;
          m_err_o   = 1'b1;
          m_rdata_o = ERR_RDATA;
          state_d   = ST_IDLE;
          cnt_clr   = 1'b1;
        end else begin
          strobe_en = 1'b1;
          state_d   = ST_WAIT;
          if (state_q == ST_IDLE) cnt_load = 1'b1;
          else                    cnt_inc  = 1'b1;
        end
      end else if (state_q == ST_WAIT) begin
        // Master abandoned the transfer: drop back silently.
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Capture address of each error completion; count saturates at 255.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else if (m_ready_o && m_err_o) begin
      err_addr_q <= m_addr_i;
      if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_addr_o  = err_addr_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed table vectors plus hand sequences for wait states,
// timeout, reset abort and error-counter saturation.
module tb_bus_fabric;
  import bus_fabric_pkg::*;

  localparam int NS = 4;
  localparam int AW = 16;

  logic               clk = 1'b0;
  logic               reset_i;
  logic [31:0]        m_addr_i, m_wdata_i, m_rdata_o;
  logic [1:0]         m_size_i;
  logic               m_rd_i, m_wr_i, m_ready_o, m_err_o;
  logic [NS*AW-1:0]   s_addr_o;
  logic [NS*32-1:0]   s_wdata_o, s_rdata_i;
  logic [NS*2-1:0]    s_size_o;
  logic [NS-1:0]      s_rd_o, s_wr_o, s_ready_i;
  logic [31:0]        err_addr_o;
  logic [7:0]         err_count_o;

  int total = 0;
  int passed = 0;

  bus_fabric #(
    .NUM_SLAVES(NS), .SEL_LSB(28), .SEL_W(4), .SLAVE_ADDR_W(AW), .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_rdata_o(m_rdata_o),
    .m_size_i(m_size_i), .m_rd_i(m_rd_i), .m_wr_i(m_wr_i),
    .m_ready_o(m_ready_o), .m_err_o(m_err_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i),
    .s_size_o(s_size_o), .s_rd_o(s_rd_o), .s_wr_o(s_wr_o), .s_ready_i(s_ready_i),
    .err_addr_o(err_addr_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  rdy;
    logic        exp_ready;
    logic        exp_err;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_wr;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic set_req(input logic [31:0] a, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic [31:0] wd);
    m_addr_i = a; m_rd_i = rd; m_wr_i = wr; m_size_i = sz; m_wdata_i = wd;
  endtask

  task automatic idle();
    m_rd_i = 1'b0; m_wr_i = 1'b0; s_ready_i = '0;
  endtask

  initial begin
    s_rdata_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hCAFE_0000};
    idle();
    set_req(32'h0, 1'b0, 1'b0, SIZE_WORD, 32'h0);

    vt[0] = '{"rd_s1",    32'h1000_0004, 1'b1, 1'b0, SIZE_WORD, 32'h0,         4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0000, 32'h1111_1111};
    vt[1] = '{"wr_s0",    32'h0000_0008, 1'b0, 1'b1, SIZE_HALF, 32'hDEAD_BEEF, 4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0001, 32'hCAFE_0000};
    vt[2] = '{"rd_s3",    32'h3000_ABCD, 1'b1, 1'b0, SIZE_BYTE, 32'h0,         4'b1000, 1'b1, 1'b0, 4'b1000, 4'b0000, 32'h3333_3333};
    vt[3] = '{"rd_unmap", 32'h7000_0000, 1'b1, 1'b0, SIZE_WORD, 32'h0,         4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 32'hBADB_05E5};
    vt[4] = '{"wr_unmap", 32'hF000_0000, 1'b0, 1'b1, SIZE_WORD, 32'h1234_5678, 4'b1111, 1'b1, 1'b1, 4'b0000, 4'b0000, 32'hBADB_05E5};
    vt[5] = '{"rd_s2",    32'h2000_0002, 1'b1, 1'b0, SIZE_BYTE, 32'h0,         4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000, 32'h2222_2222};
    vt[6] = '{"no_req",   32'h1000_0000, 1'b0, 1'b0, SIZE_WORD, 32'h0,         4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 32'h0};

    // Reset with a live request: all completions and strobes suppressed.
    reset_i = 1'b1;
    set_req(32'h1000_0000, 1'b1, 1'b0, SIZE_WORD, 32'h0);
    s_ready_i = 4'b0010;
    @(negedge clk); #1;
    chk("rst_ready", 128'(m_ready_o), 128'(1'b0));
    chk("rst_rd",    128'(s_rd_o),    128'(4'b0000));
    @(negedge clk);
    reset_i = 1'b0;
    idle();
    #1;
    chk("rst_eaddr", 128'(err_addr_o),  128'(32'h0));
    chk("rst_ecnt",  128'(err_count_o), 128'(8'h0));

    // Single-cycle vectors, presented back to back.
    foreach (vt[i]) begin
      @(negedge clk);
      set_req(vt[i].addr, vt[i].rd, vt[i].wr, vt[i].size, vt[i].wdata);
      s_ready_i = vt[i].rdy;
      #1;
      chk({vt[i].nm, "_ready"}, 128'(m_ready_o), 128'(vt[i].exp_ready));
      chk({vt[i].nm, "_err"},   128'(m_err_o),   128'(vt[i].exp_err));
      chk({vt[i].nm, "_srd"},   128'(s_rd_o),    128'(vt[i].exp_rd));
      chk({vt[i].nm, "_swr"},   128'(s_wr_o),    128'(vt[i].exp_wr));
      chk({vt[i].nm, "_saddr"}, 128'(s_addr_o),  128'({4{vt[i].addr[15:0]}}));
      chk({vt[i].nm, "_swdat"}, 128'(s_wdata_o), {4{vt[i].wdata}});
      chk({vt[i].nm, "_ssize"}, 128'(s_size_o),  128'({4{vt[i].size}}));
      if (vt[i].exp_ready) chk({vt[i].nm, "_rdata"}, 128'(m_rdata_o), 128'(vt[i].exp_rdata));
    end
    @(negedge clk); idle(); #1;
    chk("tbl_ecnt",  128'(err_count_o), 128'(8'd2));
    chk("tbl_eaddr", 128'(err_addr_o),  128'(32'hF000_0000));

    // Slave 2 answers after three wait cycles.
    @(negedge clk);
    set_req(32'h2000_0010, 1'b0, 1'b1, SIZE_WORD, 32'hA5A5_0F0F);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      s_ready_i = (c == 3) ? 4'b0100 : 4'b0000;
      #1;
      chk($sformatf("wait_swr_c%0d", c),   128'(s_wr_o),    128'(4'b0100));
      chk($sformatf("wait_ready_c%0d", c), 128'(m_ready_o), 128'(c == 3));
      chk($sformatf("wait_err_c%0d", c),   128'(m_err_o),   128'(1'b0));
    end
    @(negedge clk); idle();

    // Reset in WAIT cycle 2 aborts the transfer and clears error state.
    @(negedge clk);
    set_req(32'h3000_0040, 1'b1, 1'b0, SIZE_WORD, 32'h0);
    #1; chk("abort_srd_c0", 128'(s_rd_o), 128'(4'b1000));
    @(negedge clk);
    @(negedge clk);
    reset_i = 1'b1;
    #1;
    chk("abort_srd_rst",   128'(s_rd_o),    128'(4'b0000));
    chk("abort_ready_rst", 128'(m_ready_o), 128'(1'b0));
    @(negedge clk);
    reset_i = 1'b0; idle(); #1;
    chk("abort_srd_after", 128'(s_rd_o),      128'(4'b0000));
    chk("abort_ecnt",      128'(err_count_o), 128'(8'd0));
    chk("abort_eaddr",     128'(err_addr_o),  128'(32'h0));
    @(negedge clk);
    set_req(32'h3000_0040, 1'b1, 1'b0, SIZE_WORD, 32'h0);
    s_ready_i = 4'b1000; #1;
    chk("reissue_ready", 128'(m_ready_o), 128'(1'b1));
    chk("reissue_err",   128'(m_err_o),   128'(1'b0));
    chk("reissue_rdata", 128'(m_rdata_o), 128'(32'h3333_3333));
    @(negedge clk); idle();

`ifdef BUS_FABRIC_TIMEOUT_EN
    // Silent slave 3: error completes in cycle 8 with strobe dropped.
    @(negedge clk);
    set_req(32'h3000_0000, 1'b1, 1'b0, SIZE_WORD, 32'h0);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("tmo_ready_c%0d", c), 128'(m_ready_o), 128'(c == 8));
      chk($sformatf("tmo_srd_c%0d", c),   128'(s_rd_o),    128'((c == 8) ? 4'b0000 : 4'b1000));
      if (c == 8) begin
        chk("tmo_err",   128'(m_err_o),   128'(1'b1));
        chk("tmo_rdata", 128'(m_rdata_o), 128'(32'hBADB_05E5));
      end
    end
    @(negedge clk); idle(); #1;
    chk("tmo_eaddr", 128'(err_addr_o),  128'(32'h3000_0000));
    chk("tmo_ecnt",  128'(err_count_o), 128'(8'd1));

    // Ready arriving in the timeout cycle wins.
    @(negedge clk);
    set_req(32'h3000_0000, 1'b1, 1'b0, SIZE_WORD, 32'h0);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      s_ready_i = (c == 8) ? 4'b1000 : 4'b0000;
      #1;
      chk($sformatf("race_ready_c%0d", c), 128'(m_ready_o), 128'(c == 8));
    end
    chk("race_err",   128'(m_err_o),   128'(1'b0));
    chk("race_srd",   128'(s_rd_o),    128'(4'b1000));
    chk("race_rdata", 128'(m_rdata_o), 128'(32'h3333_3333));
    @(negedge clk); idle(); #1;
    chk("race_ecnt", 128'(err_count_o), 128'(8'd1));
`else
    // No timeout: still waiting at cycle 20, then completes when ready.
    @(negedge clk);
    set_req(32'h3000_0000, 1'b1, 1'b0, SIZE_WORD, 32'h0);
    for (int c = 0; c <= 21; c++) begin
      if (c > 0) @(negedge clk);
      s_ready_i = (c == 21) ? 4'b1000 : 4'b0000;
      #1;
      chk($sformatf("notmo_ready_c%0d", c), 128'(m_ready_o), 128'(c == 21));
      chk($sformatf("notmo_srd_c%0d", c),   128'(s_rd_o),    128'(4'b1000));
    end
    chk("notmo_err", 128'(m_err_o), 128'(1'b0));
    @(negedge clk); idle(); #1;
    chk("notmo_ecnt", 128'(err_count_o), 128'(8'd0));
`endif

    // 300 unmapped accesses saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      set_req(32'h8000_0000 + 32'(i * 4), 1'b1, 1'b0, SIZE_WORD, 32'h0);
    end
    @(negedge clk); idle(); #1;
    chk("sat_ecnt",  128'(err_count_o), 128'(8'd255));
    chk("sat_eaddr", 128'(err_addr_o),  128'(32'h8000_04AC));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
